// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the parametrised simple-dual-port RAM.
//   state_t  : sequencer states (ST_INIT = post-reset clear sweep, ST_RUN = normal)
//   merge_be : per-lane merge of a new word into an old word under byte enables
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // merge_be works on a fixed maximum width so one function serves every
  // DATA_W/BYTE_W combination; callers zero-extend in and truncate out.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_IDX_W  = 8;   // $clog2(MAX_DATA_W)

  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_DATA_W-1:0] be,
    input int                    byte_w
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (be[MAX_IDX_W'(i / byte_w)]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset clear sequencer for ram_dp_param.
// After reset it walks a counter over every address once (one per edge),
// then parks in ST_RUN until the next reset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   busy       : 1 while the sweep runs (registered)
//   init_we    : write strobe for the sweep
//   init_addr  : address being cleared on the coming edge
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          // The edge that clears the last address ends the sweep.
          if (cnt == '1) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: ;  // terminal until reset
        default: begin
          state <= ST_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign init_we   = busy;
  assign init_addr = cnt;

endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised simple-dual-port synchronous RAM.
// One byte-enabled write port, one registered read port, and a built-in
// sweep that writes INIT_VAL to every word after each reset.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : global enable for both ports
//   wena/waddr/wdata/wbe: write request, address, data, byte-lane enables
//   rena/raddr          : read request and address
//   rdata/rvalid        : registered read data, one-cycle valid pulse
//   busy                : clear sweep in progress, requests ignored
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                BYTE_W    = 8,
  parameter int                RD_BYPASS = 1,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     wena,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] wbe,
  input  logic                     rena,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NBE   = DATA_W / BYTE_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_lane
    $error("ram_dp_param: DATA_W must be a multiple of BYTE_W");
  end
  if (DATA_W > MAX_DATA_W) begin : g_too_wide
    $error("ram_dp_param: DATA_W exceeds ram_pkg::MAX_DATA_W");
  end

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  ram_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_acc;
  logic              rd_acc;
  logic              same_addr;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;

  assign wr_acc    = ena & wena & ~busy;
  assign rd_acc    = ena & rena & ~busy;
  assign same_addr = wr_acc && (waddr == raddr);

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and a latch can never be inferred.
  always_comb begin
    wr_word = DATA_W'(merge_be(MAX_DATA_W'(mem[waddr]), MAX_DATA_W'(wdata),
                               MAX_DATA_W'(wbe), BYTE_W));
    rd_word = mem[raddr];
    if (RD_BYPASS != 0 && same_addr) rd_word = wr_word;
  end

  // NOTE: the array has no reset; the post-reset sweep clears it, which
  // keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VAL;
    end else if (wr_acc && wbe != '0) begin
      mem[waddr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) rdata <= rd_word;
    end
  end

  // NBE is part of the port width; keep it named for readers.
  if (NBE < 1) begin : g_no_lanes
    $error("ram_dp_param: at least one byte lane is required");
  end

endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: self-checking bench for ram_dp_param.
// Two instances share all inputs: u_bp (RD_BYPASS=1) and u_nb (RD_BYPASS=0).
// A reference memory model plus a scoreboard queue supply expected read data.
module tb_ram_dp_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wena, rena;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdata_bp, rdata_nb;
  logic        rvalid_bp, rvalid_nb, busy_bp, busy_nb;

  always #5 clk = ~clk;

  ram_dp_param #(.RD_BYPASS(1)) u_bp (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .rena(rena), .raddr(raddr),
    .rdata(rdata_bp), .rvalid(rvalid_bp), .busy(busy_bp)
  );

  ram_dp_param #(.RD_BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .rena(rena), .raddr(raddr),
    .rdata(rdata_nb), .rvalid(rvalid_nb), .busy(busy_nb)
  );

  typedef struct {
    logic [31:0] bp;
    logic [31:0] nb;
  } exp_t;

  typedef struct {
    logic        e, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [4:0]  ra;
    logic [31:0] exp_bp, exp_nb;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] mem_m [32];
  logic [31:0] last_bp, last_nb;
  int          sweep_left;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
  endtask

  // One clock of stimulus. Called #1 after a rising edge; returns #1 after the next one.
  task automatic do_op(input logic e, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic re, input logic [4:0] ra,
                       input logic [31:0] exp_bp, input logic [31:0] exp_nb,
                       input string tag);
    logic run;
    exp_t x;
    ena = e; wena = we; waddr = wa; wdata = wd; wbe = be; rena = re; raddr = ra;
    run = (sweep_left == 0);
    check({tag, "/busy_bp"}, {31'b0, busy_bp}, {31'b0, !run});
    check({tag, "/busy_nb"}, {31'b0, busy_nb}, {31'b0, !run});
    if (e && re && run) begin
      x.bp = exp_bp;
      x.nb = exp_nb;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    if (sweep_left > 0) sweep_left--;
    if (e && we && run) mem_m[wa] = lane_merge(mem_m[wa], wd, be);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      last_bp = x.bp;
      last_nb = x.nb;
      check({tag, "/rvalid_bp"}, {31'b0, rvalid_bp}, 32'd1);
      check({tag, "/rvalid_nb"}, {31'b0, rvalid_nb}, 32'd1);
    end else begin
      check({tag, "/rvalid_bp"}, {31'b0, rvalid_bp}, 32'd0);
      check({tag, "/rvalid_nb"}, {31'b0, rvalid_nb}, 32'd0);
    end
    check({tag, "/rdata_bp"}, rdata_bp, last_bp);
    check({tag, "/rdata_nb"}, rdata_nb, last_nb);
  endtask

  task automatic idle(input string tag);
    do_op(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 32'h0, tag);
  endtask

  task automatic rd(input logic [4:0] a, input string tag);
    do_op(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, a, mem_m[a], mem_m[a], tag);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                    input string tag);
    do_op(1'b1, 1'b1, a, d, be, 1'b0, 5'd0, 32'h0, 32'h0, tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/rdata_bp"},  rdata_bp, 32'h0);
    check({tag, "/rdata_nb"},  rdata_nb, 32'h0);
    check({tag, "/rvalid_bp"}, {31'b0, rvalid_bp}, 32'd0);
    check({tag, "/rvalid_nb"}, {31'b0, rvalid_nb}, 32'd0);
    check({tag, "/busy_bp"},   {31'b0, busy_bp}, 32'd1);
    check({tag, "/busy_nb"},   {31'b0, busy_nb}, 32'd1);
  endtask

  // Reset for two edges, then release 1 time unit after an edge so the
  // next edge is sweep edge 1.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    ena = 0; wena = 0; rena = 0; waddr = 0; raddr = 0; wdata = 0; wbe = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values(tag);
    rst_n = 1'b1;
    sweep_left = 32;
    model_clear();
    sb.delete();
    last_bp = 32'h0;
    last_nb = 32'h0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'h11223344, 4'hF, 1'b0, 5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b1, 5'd5,  32'hAABBCCDD, 4'h5, 1'b0, 5'd0,  32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd5,  32'h11BB33DD, 32'h11BB33DD};
    vecs[3]  = '{1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 4'hF, 1'b1, 5'd7,  32'hDEADBEEF, 32'h00000000};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b1, 5'd3,  32'h00000005, 4'hF, 1'b1, 5'd3,  32'h0,        32'h0};
    vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  32'h00000000, 32'h00000000};
    vecs[7]  = '{1'b1, 1'b1, 5'd9,  32'h12345678, 4'h0, 1'b1, 5'd9,  32'h00000000, 32'h00000000};
    vecs[8]  = '{1'b1, 1'b1, 5'd10, 32'hCAFEF00D, 4'h3, 1'b1, 5'd10, 32'h0000F00D, 32'h00000000};
    vecs[9]  = '{1'b1, 1'b1, 5'd11, 32'h00000001, 4'hF, 1'b1, 5'd10, 32'h0000F00D, 32'h0000F00D};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd11, 32'h00000001, 32'h00000001};
    vecs[11] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        32'h0};
    vecs[14] = '{1'b1, 1'b1, 5'd0,  32'h80000000, 4'h8, 1'b1, 5'd0,  32'h80000000, 32'h00000000};

    // Reset values and busy for exactly 32 edges, then all zeros.
    apply_reset("reset1");
    for (int i = 0; i < 32; i++) idle($sformatf("sweep1_e%0d", i + 1));
    for (int i = 0; i < 32; i++) rd(5'(i), $sformatf("clr_rd%0d", i));

    // Table: lane merge, same-edge bypass, ena gating, wbe=0, boundaries.
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].e, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be,
            vecs[i].re, vecs[i].ra, vecs[i].exp_bp, vecs[i].exp_nb,
            $sformatf("vec%0d", i));
    end
    rd(5'd3, "ena0_addr3");
    rd(5'd0, "lane3_addr0");

    // Requests during the sweep are dropped.
    apply_reset("reset2");
    for (int i = 0; i < 32; i++)
      do_op(1'b1, 1'b1, 5'd0, 32'hA5A5A5A5, 4'hF, 1'b1, 5'(i), 32'h0, 32'h0,
            $sformatf("busy_req%0d", i));
    rd(5'd0,  "after_busy_addr0");
    rd(5'd31, "after_busy_addr31");

    // Fill memory, reset in the middle of a back-to-back read burst.
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h01010101 * (i + 1), 4'hF, $sformatf("fill%0d", i));
    for (int i = 0; i < 10; i++) rd(5'(i), $sformatf("burst_rd%0d", i));
    ena = 1'b1; rena = 1'b1; raddr = 5'd10;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("async_rst_hold");
    rst_n = 1'b1;
    sweep_left = 32;
    model_clear();
    last_bp = 32'h0;
    last_nb = 32'h0;
    for (int i = 0; i < 32; i++) idle($sformatf("sweep3_e%0d", i + 1));
    for (int i = 0; i < 32; i++) rd(5'(i), $sformatf("reclr_rd%0d", i));
    idle("tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised simple-dual-port synchronous RAM: one write port with byte enables, one registered read port. It is the successor to the fixed 32×32 single-port RAM with a shared bidirectional data bus. Separate read and write buses remove the tri-state. A built-in sequencer clears the array after every reset. Used as the general scratch/register-file memory behind CPU and datapath blocks.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits; must be a multiple of `BYTE_W`.
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`.
- `BYTE_W`, 8, width of one byte lane; `NBE = DATA_W/BYTE_W`.
- `RD_BYPASS`, 1, 1 = read of the address being written returns new data; 0 = returns old data.
- `INIT_VAL`, 0, word written to every location by the post-reset sweep.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: global enable; 0 blocks both ports.
- `wena` in 1: write request.
- `waddr` in `ADDR_W`: write address.
- `wdata` in `DATA_W`: write data.
- `wbe` in `NBE`: byte-lane write enables; bit k covers `wdata[k*BYTE_W +: BYTE_W]`.
- `rena` in 1: read request.
- `raddr` in `ADDR_W`: read address.
- `rdata` out `DATA_W`: registered read data.
- `rvalid` out 1: `rdata` updated by an accepted read this cycle.
- `busy` out 1: init sweep in progress; requests are ignored.

## Operation
- FSM states are `INIT` and `RUN`. Reset forces `INIT` with sweep counter = 0.
- `INIT`:
  - Each edge writes `INIT_VAL` to the counter address, all lanes, then increments the counter.
  - The edge that writes `DEPTH-1` moves the FSM to `RUN`.
  - User requests are dropped, not queued, and no `rvalid` is produced.
- `RUN`: `RUN` is terminal until the next reset.
- Write accepted when `ena & wena & !busy`. Only lanes with `wbe[k]=1` change. `wbe=0` is a legal no-op.
- Read accepted when `ena & rena & !busy`. `rdata <= mem[raddr]` and `rvalid <= 1`.
- With no accepted read, `rvalid <= 0` and `rdata` holds its last value.
- Simultaneous read and write to the same address:
  - `RD_BYPASS=1`: per lane, `rdata` gets `wbe[k] ? wdata lane : old lane`.
  - `RD_BYPASS=0`: `rdata` gets the old word.
- Read and write to different addresses on the same edge are independent.
- Addresses are always in range, since `DEPTH = 2**ADDR_W`; no wrap logic is needed.
- Reset mid-sweep or mid-operation:
  - The FSM returns to `INIT` immediately, asynchronously.
  - The sweep restarts from address 0.
  - Array contents are not reset asynchronously; the sweep overwrites them.
- Elaboration fails if `DATA_W % BYTE_W != 0`.

## Timing
- Reset values: `rdata = 0`, `rvalid = 0`, `busy = 1`.
- `busy` stays 1 for exactly `DEPTH` rising edges after `rst_n` rises. It falls after the edge that writes `DEPTH-1`.
- The first request can be accepted on edge `DEPTH+1`.
- Read latency is 1 cycle. A request sampled at edge N gives `rdata`/`rvalid` valid after edge N, and `rvalid` is high for one cycle.
- Write latency is 1 edge. A read at edge N+1 sees data written at edge N.
- Back-to-back reads every cycle are supported, so `rvalid` stays high continuously.

## Structure
- Shared package `ram_pkg` holds:
  - state encodings `ST_INIT` and `ST_RUN`;
  - the lane-merge function `merge_be(old, new, be)`.
- Sub-module `ram_init_seq` holds the FSM plus the `ADDR_W`-bit sweep counter. It outputs `busy`, `init_we` and `init_addr`.
- The top level muxes `init_*` or user signals onto the array write port.
- The top level owns the array, the read register and the bypass compare.

## Test plan
All scenarios use default parameters: `DATA_W=32`, `ADDR_W=5`, `DEPTH=32`.
1. Release reset and count edges → `busy` is 1 for exactly 32 edges. Reading address 0..31 afterwards returns `0x00000000`, one `rvalid` per read.
2. Write `0x11223344` to addr 5 with `wbe=4'b1111`, then `0xAABBCCDD` with `wbe=4'b0101`, then read addr 5 → `rdata = 0x11BB33DD` one cycle after the read.
3. Same-edge write `0xDEADBEEF` (`wbe=1111`) and read to addr 7, which holds 0 → `rdata = 0xDEADBEEF` with `RD_BYPASS=1`, `0x00000000` with `RD_BYPASS=0`.
4. Apply `ena=0` with `wena=rena=1` on addr 3 with data `0x5` → addr 3 stays 0 and `rvalid` stays 0.
5. Issue write/read requests during `busy` → no effect and no `rvalid`.
6. Write all 32 words, then assert `rst_n=0` in the middle of a burst of 32 consecutive reads → outputs return to their reset values at once. After the new sweep, all locations read 0.
